// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake and holds the fetched instruction for the decode controller.
module instr_fetch #(
    parameter int unsigned      ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              redirect_pending_q, redirect_pending_d;
    logic [ADDR_W-1:0] target;

    // Redirect target is forced word-aligned.
    assign target = redirect_pc & ~ADDR_W'(3);

    // Next-state and datapath updates for the fetch FSM.
    always_comb begin
        state_d            = state_q;
        fetch_pc_d         = fetch_pc_q;
        imem_req_d         = imem_req_q;
        imem_addr_d        = imem_addr_q;
        instr_d            = instr_q;
        instr_valid_d      = instr_valid_q;
        pc_d               = pc_q;
        redirect_pending_d = redirect_pending_q;

        case (state_q)
            S_BOOT: begin
                imem_req_d = 1'b1;
                state_d    = S_REQ;
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    instr_d       = '0;
                    fetch_pc_d    = target;
                    imem_addr_d   = target;
                end else begin
                    imem_addr_d   = fetch_pc_q;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Drop returned data, re-request at the new target.
                        fetch_pc_d         = target;
                        imem_addr_d        = target;
                        redirect_pending_d = 1'b0;
                    end else if (redirect_pending_q) begin
                        // Data belongs to the superseded path; refetch.
                        imem_addr_d        = fetch_pc_q;
                        redirect_pending_d = 1'b0;
                    end else begin
                        instr_d       = imem_rdata;
                        pc_d          = imem_addr_q;
                        instr_valid_d = 1'b1;
                        fetch_pc_d    = imem_addr_q + ADDR_W'(4);
                        imem_req_d    = 1'b0;
                        state_d       = S_HOLD;
                    end
                end else if (redirect) begin
                    // Address must stay put until ack; remember the target.
                    fetch_pc_d         = target;
                    redirect_pending_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    instr_d       = '0;
                    fetch_pc_d    = target;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = target;
                    state_d       = S_REQ;
                end else if (instr_valid_q && !stall) begin
                    instr_valid_d = 1'b0;
                    instr_d       = '0;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = fetch_pc_q;
                    state_d       = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= S_BOOT;
            fetch_pc_q         <= RESET_PC;
            imem_req_q         <= 1'b0;
            imem_addr_q        <= '0;
            instr_q            <= '0;
            instr_valid_q      <= 1'b0;
            pc_q               <= '0;
            redirect_pending_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            fetch_pc_q         <= fetch_pc_d;
            imem_req_q         <= imem_req_d;
            imem_addr_q        <= imem_addr_d;
            instr_q            <= instr_d;
            instr_valid_q      <= instr_valid_d;
            pc_q               <= pc_d;
            redirect_pending_q <= redirect_pending_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign opcode      = instr_q[31:26];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign funct       = instr_q[5:0];
    assign imm         = instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: nominal fetch, stall, slow memory,
// redirects (idle and outstanding), PC wrap-around and async reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst, imem_ack, stall, redirect;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    logic        rst1, imem_ack1;
    logic [31:0] imem_rdata1;
    logic        imem_req1, instr_valid1;
    logic [31:0] imem_addr1, instr1, pc1, pc_plus41;
    logic [5:0]  opcode1, funct1;
    logic [4:0]  rs1, rt1, rd1;
    logic [15:0] imm1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
        .instr_valid(instr_valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .funct(funct), .imm(imm), .pc(pc), .pc_plus4(pc_plus4)
    );

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst1), .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_ack(imem_ack1), .imem_rdata(imem_rdata1), .stall(1'b0),
        .redirect(1'b0), .redirect_pc(32'h0), .instr(instr1),
        .instr_valid(instr_valid1), .opcode(opcode1), .rs(rs1), .rt(rt1), .rd(rd1),
        .funct(funct1), .imm(imm1), .pc(pc1), .pc_plus4(pc_plus41)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL reset_req got %0h exp 0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin failed++; $display("FAIL reset_addr got %0h exp 0", imem_addr); end
        tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %0h exp 0", instr_valid); end
        tests++; if (instr !== 32'h0) begin failed++; $display("FAIL reset_instr got %0h exp 0", instr); end
        tests++; if (pc !== 32'h0) begin failed++; $display("FAIL reset_pc got %0h exp 0", pc); end
        rst = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL boot_req got %0h exp 0", imem_req); end
        tick();
        tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL first_req got %0h exp 1", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin failed++; $display("FAIL first_addr got %0h exp 0", imem_addr); end
    endtask

    task automatic test_fetch();
        imem_ack = 1'b1; imem_rdata = 32'h8C01_0004;
        tick();
        tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL f0_valid got %0h exp 1", instr_valid); end
        tests++; if (opcode !== 6'b100011) begin failed++; $display("FAIL f0_opcode got %0h exp 23", opcode); end
        tests++; if (rt !== 5'd1) begin failed++; $display("FAIL f0_rt got %0h exp 1", rt); end
        tests++; if (imm !== 16'h0004) begin failed++; $display("FAIL f0_imm got %0h exp 4", imm); end
        tests++; if (pc !== 32'h0) begin failed++; $display("FAIL f0_pc got %0h exp 0", pc); end
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL f0_req got %0h exp 0", imem_req); end
        imem_ack = 1'b0;
        tick();
        tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL f1_consume_valid got %0h exp 0", instr_valid); end
        tests++; if (opcode !== 6'd0) begin failed++; $display("FAIL f1_opcode_idle got %0h exp 0", opcode); end
        tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL f1_req got %0h exp 1", imem_req); end
        tests++; if (imem_addr !== 32'h4) begin failed++; $display("FAIL f1_addr got %0h exp 4", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hAC01_0008;
        tick();
        imem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL f1_valid got %0h exp 1", instr_valid); end
        tests++; if (opcode !== 6'b101011) begin failed++; $display("FAIL f1_opcode got %0h exp 2b", opcode); end
        tests++; if (pc !== 32'h4) begin failed++; $display("FAIL f1_pc got %0h exp 4", pc); end
        tests++; if (pc_plus4 !== 32'h8) begin failed++; $display("FAIL f1_pc_plus4 got %0h exp 8", pc_plus4); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL stall_valid[%0d] got %0h exp 1", i, instr_valid); end
            tests++; if (instr !== 32'hAC01_0008) begin failed++; $display("FAIL stall_instr[%0d] got %0h exp ac010008", i, instr); end
            tests++; if (pc !== 32'h4) begin failed++; $display("FAIL stall_pc[%0d] got %0h exp 4", i, pc); end
            tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL stall_req[%0d] got %0h exp 0", i, imem_req); end
        end
        stall = 1'b0;
        tick();
        tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL unstall_req got %0h exp 1", imem_req); end
        tests++; if (imem_addr !== 32'h8) begin failed++; $display("FAIL unstall_addr got %0h exp 8", imem_addr); end
        tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL unstall_valid got %0h exp 0", instr_valid); end
    endtask

    task automatic test_delayed_ack();
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL wait_req[%0d] got %0h exp 1", i, imem_req); end
            tests++; if (imem_addr !== 32'h8) begin failed++; $display("FAIL wait_addr[%0d] got %0h exp 8", i, imem_addr); end
            tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL wait_valid[%0d] got %0h exp 0", i, instr_valid); end
        end
        imem_ack = 1'b1; imem_rdata = 32'h0022_1820;
        tick();
        imem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL slow_valid got %0h exp 1", instr_valid); end
        tests++; if (pc !== 32'h8) begin failed++; $display("FAIL slow_pc got %0h exp 8", pc); end
        tests++; if ({rs, rt, rd} !== {5'd1, 5'd2, 5'd3}) begin failed++; $display("FAIL slow_regs got %0h/%0h/%0h exp 1/2/3", rs, rt, rd); end
        tests++; if (funct !== 6'h20) begin failed++; $display("FAIL slow_funct got %0h exp 20", funct); end
    endtask

    task automatic test_redirect_hold();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0; stall = 1'b0;
        tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL rdh_valid got %0h exp 0", instr_valid); end
        tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL rdh_req got %0h exp 1", imem_req); end
        tests++; if (imem_addr !== 32'h40) begin failed++; $display("FAIL rdh_addr got %0h exp 40", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
        tick();
        imem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL rdh_fetch_valid got %0h exp 1", instr_valid); end
        tests++; if (pc !== 32'h40) begin failed++; $display("FAIL rdh_pc got %0h exp 40", pc); end
        tests++; if (opcode !== 6'b001000) begin failed++; $display("FAIL rdh_opcode got %0h exp 8", opcode); end
    endtask

    task automatic test_redirect_pending();
        redirect = 1'b1; redirect_pc = 32'h8;
        tick();
        tests++; if (imem_addr !== 32'h8) begin failed++; $display("FAIL rdp_setup_addr got %0h exp 8", imem_addr); end
        redirect_pc = 32'h83;
        tick();
        redirect = 1'b0;
        tests++; if (imem_addr !== 32'h8) begin failed++; $display("FAIL rdp_hold0_addr got %0h exp 8", imem_addr); end
        tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL rdp_hold0_req got %0h exp 1", imem_req); end
        tick();
        tests++; if (imem_addr !== 32'h8) begin failed++; $display("FAIL rdp_hold1_addr got %0h exp 8", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        tick();
        imem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL rdp_discard_valid got %0h exp 0", instr_valid); end
        tests++; if (instr !== 32'h0) begin failed++; $display("FAIL rdp_discard_instr got %0h exp 0", instr); end
        tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL rdp_req got %0h exp 1", imem_req); end
        tests++; if (imem_addr !== 32'h80) begin failed++; $display("FAIL rdp_addr got %0h exp 80", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h3C01_0000;
        tick();
        imem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL rdp_fetch_valid got %0h exp 1", instr_valid); end
        tests++; if (pc !== 32'h80) begin failed++; $display("FAIL rdp_pc got %0h exp 80", pc); end
    endtask

    task automatic test_wrap_and_async_reset();
        rst1 = 1'b0;
        tick();
        tests++; if (imem_addr1 !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_addr0 got %0h exp fffffffc", imem_addr1); end
        imem_ack1 = 1'b1; imem_rdata1 = 32'h8C01_0004;
        tick();
        imem_ack1 = 1'b0;
        tests++; if (pc1 !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_pc got %0h exp fffffffc", pc1); end
        tests++; if (pc_plus41 !== 32'h0) begin failed++; $display("FAIL wrap_pc_plus4 got %0h exp 0", pc_plus41); end
        tick();
        tests++; if (imem_req1 !== 1'b1) begin failed++; $display("FAIL wrap_req1 got %0h exp 1", imem_req1); end
        tests++; if (imem_addr1 !== 32'h0) begin failed++; $display("FAIL wrap_addr1 got %0h exp 0", imem_addr1); end
        #2 rst1 = 1'b1;
        #1;
        tests++; if (imem_req1 !== 1'b0) begin failed++; $display("FAIL async_req got %0h exp 0", imem_req1); end
        tests++; if (instr_valid1 !== 1'b0) begin failed++; $display("FAIL async_valid got %0h exp 0", instr_valid1); end
        tests++; if (imem_addr1 !== 32'h0) begin failed++; $display("FAIL async_addr got %0h exp 0", imem_addr1); end
        #1 rst1 = 1'b0;
        tick();
        tests++; if (imem_req1 !== 1'b1) begin failed++; $display("FAIL refetch_req got %0h exp 1", imem_req1); end
        tests++; if (imem_addr1 !== 32'hFFFF_FFFC) begin failed++; $display("FAIL refetch_addr got %0h exp fffffffc", imem_addr1); end
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst1 = 1'b1; imem_ack1 = 1'b0; imem_rdata1 = '0;
        tick();
        tick();
        test_reset();
        test_fetch();
        test_stall();
        test_delayed_ack();
        test_redirect_hold();
        test_redirect_pending();
        test_wrap_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
